dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 51 +++++
 rtl/dmem_ram_be.sv | 35 +++
 rtl/dmem_ctrl.sv | 154 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, encodings and lane helpers for dmem_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [2:0] LED_OFS = 3'd0;
    localparam logic [2:0] CYC_OFS = 3'd4;

    function automatic logic [3:0] byte_en(input logic [1:0] ofs, input logic [1:0] sz);
        case (sz)
            SZ_B:    byte_en = 4'b0001 << ofs;
            SZ_H:    byte_en = ofs[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [1:0] sz);
        case (sz)
            SZ_B:    store_lanes = {4{wd[7:0]}};
            SZ_H:    store_lanes = {2{wd[15:0]}};
            default: store_lanes = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] ofs,
                                                input logic [1:0] sz, input logic uns);
        logic [31:0] s;
        s = raw >> {ofs, 3'b000};
        case (sz)
            SZ_B:    load_extend = {{24{s[7] & ~uns}}, s[7:0]};
            SZ_H:    load_extend = {{16{s[15] & ~uns}}, s[15:0]};
            default: load_extend = s;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram_be.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram_be
// Description : DEPTH x 32 synchronous RAM with per-byte write enables.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram_be #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic [3:0]               i_be,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_q;

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_q <= r_mem[i_addr];
        end
        for (int i = 0; i < 4; i++) begin
            if (i_be[i]) begin
                r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
        end
    end

    assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Data-memory controller: RAM with byte lanes plus LED and
//               cycle-counter MMIO registers, configurable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_8000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [31:0]       led
);

    localparam int         c_aw      = $clog2(DEPTH);
    localparam logic [2:0] c_ws_last = 3'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    state_t            r_state;
    logic [2:0]        r_wcnt;
    logic              r_we;
    logic [c_aw+1:0]   r_addr_lo;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [31:0]       r_wdata;
    logic              r_is_mmio;
    logic              r_ready;
    logic              r_err;
    logic [31:0]       r_led;
    logic [31:0]       r_cyc;
    logic [31:0]       r_mmio_q;

    logic              w_in_ram;
    logic              w_in_mmio;
    logic              w_fault;
    logic              w_ram_en;
    logic [3:0]        w_ram_be;
    logic [31:0]       w_ram_q;

    // Fault decode works on live inputs so a bad access skips WAIT/ACCESS.
    assign w_in_ram  = (addr >> (c_aw + 2)) == 32'd0;
    assign w_in_mmio = addr[31:3] == MMIO_BASE[31:3];
    assign w_fault   = (size == 2'b11)
                     || (size == SZ_H && addr[0])
                     || (size == SZ_W && addr[1:0] != 2'b00)
                     || (!w_in_ram && !w_in_mmio)
                     || (w_in_mmio && addr[2] == LED_OFS[2] && size != SZ_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wcnt    <= 3'd0;
            r_we      <= 1'b0;
            r_addr_lo <= '0;
            r_size    <= SZ_B;
            r_uns     <= 1'b0;
            r_wdata   <= 32'd0;
            r_is_mmio <= 1'b0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_led     <= 32'd0;
            r_cyc     <= 32'd0;
            r_mmio_q  <= 32'd0;
        end else begin
            r_cyc   <= r_cyc + 32'd1;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we      <= we;
                        r_addr_lo <= addr[c_aw+1:0];
                        r_size    <= size;
                        r_uns     <= uns;
                        r_wdata   <= wdata;
                        r_is_mmio <= w_in_mmio;
                        if (w_fault) begin
                            r_state <= RESP;
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            r_state <= WAIT;
                            r_wcnt  <= 3'd0;
                        end else begin
                            r_state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (r_wcnt == c_ws_last) begin
                        r_state <= ACCESS;
                    end else begin
                        r_wcnt <= r_wcnt + 3'd1;
                    end
                end
                ACCESS: begin
                    r_state <= RESP;
                    r_ready <= 1'b1;
                    if (r_is_mmio) begin
                        r_mmio_q <= (r_addr_lo[2] == CYC_OFS[2]) ? r_cyc : r_led;
                        // Stores to the cycle counter fall through silently.
                        if (r_we && r_addr_lo[2] == LED_OFS[2]) begin
                            r_led <= r_wdata;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_ram_en = (r_state == ACCESS) && !r_we && !r_is_mmio;
    assign w_ram_be = ((r_state == ACCESS) && r_we && !r_is_mmio)
                    ? byte_en(r_addr_lo[1:0], r_size) : 4'b0000;

    dmem_ram_be #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_be    (w_ram_be),
        .i_addr  (r_addr_lo[c_aw+1:2]),
        .i_wdata (store_lanes(r_wdata, r_size)),
        .o_rdata (w_ram_q)
    );

    assign ready = r_ready;
    assign err   = r_err;
    assign led   = r_led;
    assign rdata = (r_ready && !r_err)
                 ? load_extend(r_is_mmio ? r_mmio_q : w_ram_q, r_addr_lo[1:0], r_size, r_uns)
                 : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Directed self-checking bench; three controllers with 0/3/2 wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    localparam logic [31:0] c_mmio = 32'h0000_8000;

    logic             clk;
    logic [2:0]       rst_v;
    logic [2:0]       req_v;
    logic [2:0]       we_v;
    logic [2:0][31:0] addr_v;
    logic [2:0][1:0]  size_v;
    logic [2:0]       uns_v;
    logic [2:0][31:0] wdata_v;
    logic [2:0]       ready_v;
    logic [2:0][31:0] rdata_v;
    logic [2:0]       err_v;
    logic [2:0][31:0] led_v;

    int n_cmp = 0;
    int n_bad = 0;
    int tcyc  = 0;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int WS = (i == 0) ? 0 : ((i == 1) ? 3 : 2);
        dmem_ctrl #(
            .DATA_W      (32),
            .DEPTH       (1024),
            .WAIT_STATES (WS),
            .MMIO_BASE   (c_mmio)
        ) u_dut (
            .clk   (clk),
            .rst   (rst_v[i]),
            .req   (req_v[i]),
            .we    (we_v[i]),
            .addr  (addr_v[i]),
            .size  (size_v[i]),
            .uns   (uns_v[i]),
            .wdata (wdata_v[i]),
            .ready (ready_v[i]),
            .rdata (rdata_v[i]),
            .err   (err_v[i]),
            .led   (led_v[i])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) tcyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request/response; lat counts clock edges from the accept edge to ready.
    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; size_v[d] = sz; uns_v[d] = u; wdata_v[d] = wd;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lat++;
            if (ready_v[d]) break;
            if (lat == 1) begin
                we_v[d] = ~w; addr_v[d] = ~a; size_v[d] = ~sz; uns_v[d] = ~u; wdata_v[d] = ~wd;
            end
        end
        rd = rdata_v[d];
        e  = err_v[d];
        req_v[d] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    logic [31:0] cyc1, cyc2;
    int          t1, t2;
    int          npulse, last, cnt;

    initial begin
        rst_v = 3'b111; req_v = '0; we_v = '0; addr_v = '0; size_v = '0; uns_v = '0; wdata_v = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", {31'd0, ready_v[d]}, 32'd0);
            chk("rst_err",   {31'd0, err_v[d]},   32'd0);
            chk("rst_rdata", rdata_v[d],          32'd0);
            chk("rst_led",   led_v[d],            32'd0);
        end
        rst_v = 3'b000;

        // Zero wait states: word store then load
        xact(0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, e, lat);
        chk("ws0_st_lat", lat, 32'd2);
        chk("ws0_st_err", {31'd0, e}, 32'd0);
        xact(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, e, lat);
        chk("ws0_ld_data", rd, 32'hDEADBEEF);
        chk("ws0_ld_err", {31'd0, e}, 32'd0);
        chk("ws0_ld_lat", lat, 32'd2);

        // Three wait states: byte lanes and extension
        xact(1, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, e, lat);
        xact(1, 1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080, rd, e, lat);
        chk("ws3_stb_lat", lat, 32'd5);
        xact(1, 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, rd, e, lat);
        chk("ws3_lbs", rd, 32'hFFFFFF80);
        chk("ws3_lbs_lat", lat, 32'd5);
        xact(1, 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, rd, e, lat);
        chk("ws3_lbu", rd, 32'h00000080);
        xact(1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, e, lat);
        chk("ws3_lw", rd, 32'h80ADBEEF);
        chk("ws3_lw_lat", lat, 32'd5);
        xact(1, 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, rd, e, lat);
        chk("ws3_lhs", rd, 32'hFFFF80AD);

        // Back-to-back loads with req held high
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'h10; size_v[1] = 2'b10; uns_v[1] = 1'b0;
        npulse = 0; last = 0; cnt = 0;
        for (int k = 0; k < 100 && npulse < 4; k++) begin
            @(negedge clk);
            cnt++;
            if (ready_v[1]) begin
                npulse++;
                if (npulse > 1) chk("b2b_gap", cnt - last, 32'd6);
                chk("b2b_data", rdata_v[1], 32'h80ADBEEF);
                last = cnt;
            end
        end
        req_v[1] = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ready_v[1]) npulse++;
        end
        chk("b2b_count", npulse, 32'd4);

        // MMIO: LED write, ignored counter write, counter reads
        xact(0, 1'b1, c_mmio, 2'b10, 1'b0, 32'h5, rd, e, lat);
        chk("led_val", led_v[0], 32'h5);
        chk("led_err", {31'd0, e}, 32'd0);
        xact(0, 1'b1, c_mmio + 32'd4, 2'b10, 1'b0, 32'h77, rd, e, lat);
        chk("cyc_st_err", {31'd0, e}, 32'd0);
        chk("cyc_st_led", led_v[0], 32'h5);
        xact(0, 1'b0, c_mmio + 32'd4, 2'b10, 1'b0, 32'h0, rd, e, lat);
        cyc1 = rd; t1 = tcyc;
        repeat (10) @(negedge clk);
        xact(0, 1'b0, c_mmio + 32'd4, 2'b10, 1'b0, 32'h0, rd, e, lat);
        cyc2 = rd; t2 = tcyc;
        chk("cyc_delta", cyc2 - cyc1, t2 - t1);
        xact(0, 1'b0, c_mmio, 2'b10, 1'b0, 32'h0, rd, e, lat);
        chk("led_read", rd, 32'h5);

        // Faults
        xact(0, 1'b0, 32'h01, 2'b01, 1'b0, 32'h0, rd, e, lat);
        chk("flt_half_err", {31'd0, e}, 32'd1);
        chk("flt_half_rd", rd, 32'd0);
        chk("flt_half_lat", lat, 32'd1);
        xact(0, 1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, rd, e, lat);
        chk("flt_oor_err", {31'd0, e}, 32'd1);
        chk("flt_oor_rd", rd, 32'd0);
        xact(0, 1'b1, c_mmio, 2'b00, 1'b0, 32'hFF, rd, e, lat);
        chk("flt_ledb_err", {31'd0, e}, 32'd1);
        chk("flt_ledb_lat", lat, 32'd1);
        chk("flt_ledb_led", led_v[0], 32'h5);
        xact(0, 1'b1, 32'h12, 2'b10, 1'b0, 32'h0, rd, e, lat);
        chk("flt_mis_err", {31'd0, e}, 32'd1);
        xact(0, 1'b0, 32'h10, 2'b11, 1'b0, 32'h0, rd, e, lat);
        chk("flt_sz3_err", {31'd0, e}, 32'd1);
        xact(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, e, lat);
        chk("flt_nochg", rd, 32'hDEADBEEF);

        // Reset abort during WAIT
        xact(2, 1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFEF00D, rd, e, lat);
        chk("ws2_st_lat", lat, 32'd4);
        @(negedge clk);
        req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 32'h20; size_v[2] = 2'b10; wdata_v[2] = 32'h1234;
        @(negedge clk);
        rst_v[2] = 1'b1;
        req_v[2] = 1'b0;
        npulse = 0;
        repeat (4) begin
            @(negedge clk);
            if (ready_v[2]) npulse++;
        end
        chk("abort_ready", npulse, 32'd0);
        rst_v[2] = 1'b0;
        xact(2, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, e, lat);
        chk("abort_keep", rd, 32'hCAFEF00D);
        chk("abort_lat", lat, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
